// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_pkg
// Purpose  : Shared types, constants and the eligible-consumer search used by
//            the 4-way dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    localparam int NCONS = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // First index k with mask[k]=1, scanning base, base+1, ... modulo NCONS.
    // Returns base when the mask is empty; callers only use it on a nonzero mask.
    function automatic logic [1:0] next_eligible(input logic [NCONS-1:0] mask,
                                                 input logic [1:0]       base);
        logic [1:0] idx;
        logic       found;
        next_eligible = base;
        found         = 1'b0;
        for (int i = 0; i < NCONS; i++) begin
            idx = base + 2'(i);
            if (!found && mask[idx]) begin
                next_eligible = idx;
                found         = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmux4way.sv
`default_nettype none
// ============================================================================
// Module   : dmux4way
// Purpose  : 1-to-4 demultiplexer; routes a single bit onto the output lane
//            chosen by the select, all other lanes driven low.
// Revision : 1.0 - initial release
// ============================================================================
module dmux4way (
    input  logic       i_din,
    input  logic [1:0] i_sel,
    output logic [3:0] o_dout
);

    // Steer the input bit onto the selected lane only.
    always_comb begin
        o_dout        = 4'b0000;
        o_dout[i_sel] = i_din;
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_4way.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_4way
// Purpose  : Single-entry buffer that takes words from one producer and hands
//            each to one of four consumers, chosen round-robin among the
//            consumers enabled by en_mask. Full throughput: a word can be
//            accepted in the same cycle the held word is dispatched.
// Options  : DISPATCH_4WAY_STATS_EN - adds disp_count, per-consumer 8-bit
//            wrapping dispatch counters.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_4way
    import dispatch_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [NCONS-1:0]        en_mask,
    output logic [NCONS-1:0]        out_valid,
    input  logic [NCONS-1:0]        out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [1:0]              out_sel
`ifdef DISPATCH_4WAY_STATS_EN
    ,
    output logic [NCONS-1:0][7:0]   disp_count
`endif
);

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_sel;
    logic [DATA_W-1:0]   r_data;
    logic                w_hold;
    logic                w_dispatch;
    logic                w_transfer;
    logic                w_mask_any;
    logic [1:0]          w_base;
    logic [1:0]          w_target;

    assign w_hold     = (r_state == HOLD);
    assign w_mask_any = |en_mask;
    assign w_dispatch = out_valid[r_sel] & out_ready[r_sel];
    assign w_transfer = in_valid & in_ready;

    // A word accepted alongside a dispatch must search from the already
    // advanced pointer, otherwise back-to-back words would hit the same target.
    assign w_base     = w_dispatch ? (r_sel + 2'd1) : r_rr_ptr;
    assign w_target   = next_eligible(en_mask, w_base);

    assign out_data   = r_data;
    assign out_sel    = r_sel;

    // HOLD flag fanned out to the targeted consumer's valid lane.
    dmux4way u_dmux (
        .i_din  (w_hold),
        .i_sel  (r_sel),
        .o_dout (out_valid)
    );

    // Next-state and producer-side handshake; in_ready is forced low in reset.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            EMPTY: begin
                in_ready = rst_n & w_mask_any;
                if (in_ready && in_valid) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                in_ready = rst_n & w_dispatch & w_mask_any;
                if (w_dispatch && !(in_ready && in_valid)) begin
                    w_next_state = EMPTY;
                end
            end
            default: begin
                w_next_state = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Buffer, target and round-robin pointer; the target is latched at
    // acceptance and never re-evaluated against a changing mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 2'd0;
            r_sel    <= 2'd0;
            r_data   <= '0;
        end else begin
            if (w_dispatch) begin
                r_rr_ptr <= r_sel + 2'd1;
            end
            if (w_transfer) begin
                r_sel  <= w_target;
                r_data <= in_data;
            end
        end
    end

`ifdef DISPATCH_4WAY_STATS_EN
    logic [NCONS-1:0][7:0] r_disp_count;

    // Per-consumer dispatch counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_count <= '0;
        end else if (w_dispatch) begin
            r_disp_count[r_sel] <= r_disp_count[r_sel] + 8'd1;
        end
    end

    assign disp_count = r_disp_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_4way.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_4way
// Purpose  : Directed self-checking bench for dispatch_4way with a queue of
//            expected (data, target) pairs matched against each dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_4way;

    localparam int DATA_W = 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        sel;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        en_mask;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
`ifdef DISPATCH_4WAY_STATS_EN
    logic [3:0][7:0]   disp_count;
`endif

    exp_t       sb[$];
    logic [1:0] exp_sel;
    int         n_checks;
    int         n_errors;

    dispatch_4way #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .en_mask    (en_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel)
`ifdef DISPATCH_4WAY_STATS_EN
        ,
        .disp_count (disp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge, match any dispatch against the queue and
    // record any acceptance; then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("disp_sel", 32'(out_sel), 32'(e.sel));
                chk("disp_data", 32'(out_data), 32'(e.data));
                chk("disp_valid", 32'(out_valid), 32'(4'b0001 << e.sel));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb.push_back('{in_data, exp_sel});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (sb.size() != 0) cycle();
        end
        chk("drain_empty", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        en_mask   = 4'hF;
        out_ready = 4'hF;
        exp_sel   = 2'd0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        do_reset();

        // Round-robin over all four consumers at full rate
        en_mask   = 4'hF;
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1111 * 16'(i + 1);
            exp_sel  = 2'(i % 4);
            #1;
            chk("rr_in_ready", 32'(in_ready), 1);
            cycle();
        end
        drain();

        // Stall on a non-ready target, then release it
        do_reset();
        en_mask   = 4'b0100;
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 16'hABCD;
        exp_sel   = 2'd2;
        cycle();
        in_data   = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_out_valid", 32'(out_valid), 32'(4'b0100));
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_data", 32'(out_data), 32'(16'hABCD));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 4'b0100;
        cycle();
        chk("stall_released", 32'(sb.size()), 0);
        // Pointer must now sit at 3
        en_mask   = 4'hF;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        exp_sel   = 2'd3;
        cycle();
        drain();

        // Sparse mask: only consumers 1 and 3
        do_reset();
        en_mask   = 4'b1010;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hC000 + 16'(i);
            exp_sel  = (i % 2 == 0) ? 2'd1 : 2'd3;
            cycle();
        end
        drain();
        en_mask  = 4'b0000;
        in_valid = 1'b1;
        #1;
        chk("nomask_in_ready", 32'(in_ready), 0);
        cycle();
        chk("nomask_out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;

        // Target kept when its mask bit drops during HOLD
        do_reset();
        en_mask   = 4'hF;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 16'h5A5A;
        exp_sel   = 2'd0;
        cycle();
        in_valid  = 1'b0;
        en_mask   = 4'b1110;
        cycle();
        chk("mask_drop_sel", 32'(out_sel), 0);
        chk("mask_drop_valid", 32'(out_valid), 32'(4'b0001));
        out_ready = 4'hF;
        cycle();
        drain();

        // Reset in the middle of HOLD
        do_reset();
        en_mask   = 4'hF;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        exp_sel   = 2'd0;
        cycle();
        in_data   = 16'hDEAD;
        exp_sel   = 2'd1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        cycle();
        chk("prerst_sel", 32'(out_sel), 1);
        chk("prerst_valid", 32'(out_valid), 32'(4'b0010));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_sel", 32'(out_sel), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        exp_sel   = 2'd0;
        cycle();
        drain();

`ifdef DISPATCH_4WAY_STATS_EN
        // Counter wrap: 257 dispatches to consumer 0
        do_reset();
        en_mask   = 4'b0001;
        out_ready = 4'hF;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            exp_sel  = 2'd0;
            cycle();
        end
        drain();
        chk("cnt0", 32'(disp_count[0]), 1);
        chk("cnt1", 32'(disp_count[1]), 0);
        chk("cnt2", 32'(disp_count[2]), 0);
        chk("cnt3", 32'(disp_count[3]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
